// File: rtl/tdm_demux8.sv
// tdm_demux8: receive side of an N_CH:1 TDM link; assembles one bit per enabled slot
// into a parallel word, published with a one-cycle valid strobe when the frame completes.
module tdm_demux8 #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame,
    input  logic             din,
    output logic [N_CH-1:0]  Q,
    output logic             valid,
    output logic             sync_err,
    output logic [SEL_W-1:0] slot,
    output logic             busy
);
    typedef enum logic {IDLE, RECV} state_t;

    state_t            state, state_n;
    logic [N_CH-1:0]   shadow, shadow_n, q_n;
    logic [SEL_W-1:0]  slot_n;
    logic              valid_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= '0;
            Q        <= '0;
            slot     <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            shadow   <= shadow_n;
            Q        <= q_n;
            slot     <= slot_n;
            valid    <= valid_n;
            sync_err <= err_n;
        end
    end

    // A frame marker always restarts at slot 0; mid-frame it also flags the dropped word.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        q_n      = Q;
        slot_n   = slot;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        if (en) begin
            if (frame) begin
                shadow_n[0] = din;
                slot_n      = SEL_W'(1);
                state_n     = RECV;
                err_n       = (state == RECV);
            end else if (state == RECV) begin
                if (slot == SEL_W'(N_CH-1)) begin
                    q_n     = {din, shadow[N_CH-2:0]};
                    valid_n = 1'b1;
                    slot_n  = '0;
                    state_n = IDLE;
                end else begin
                    shadow_n[slot] = din;
                    slot_n         = slot + SEL_W'(1);
                end
            end
        end
    end

    assign busy = (state == RECV);
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: scoreboard bench for tdm_demux8; expected words are queued as frames
// are driven and matched against words captured whenever valid pulses.
module tb_tdm_demux8;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, frame = 1'b0, din = 1'b0;
    logic [7:0] Q;
    logic       valid, sync_err, busy;
    logic [2:0] slot;
    logic [7:0] exp_q[$], obs_q[$];
    int         vcyc[$];
    int         cycle = 0, err_cnt = 0, n_cmp = 0, n_fail = 0;

    tdm_demux8 dut (.clk(clk), .rst(rst), .en(en), .frame(frame), .din(din),
                    .Q(Q), .valid(valid), .sync_err(sync_err), .slot(slot), .busy(busy));

    always #5 clk = ~clk;

    // Observe every edge 1 time unit after it, once registered outputs have settled.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            obs_q.push_back(Q);
            vcyc.push_back(cycle);
        end
        if (sync_err) err_cnt++;
        cycle++;
    end

    task automatic cyc(input logic e, input logic f, input logic d);
        en = e; frame = f; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) cyc(1'b1, i == 0, w[i]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        n_cmp++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", Q); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", sync_err); end
        n_cmp++; if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot got %0d want 0", slot); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_continuous;
        send_word(8'hA5);
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid got %b want 1", valid); end
        n_cmp++; if (slot !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL cont_slot got %0d/%b want 0/0", slot, busy); end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL cont_pulse got %b want 0", valid); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cont_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_cmp++; if (o !== x) begin n_fail++; $display("FAIL cont_word got %h want %h", o, x); end
        end
        obs_q.delete(); exp_q.delete(); vcyc.delete();
    endtask

    task automatic test_gapped;
        logic [7:0] w = 8'hA5;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, i == 0, w[i]);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (slot !== 3'((i + 1) % 8)) begin n_fail++; $display("FAIL gap_slot%0d got %0d want %0d", i, slot, (i + 1) % 8); end
        end
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL gap_count got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_cmp++; if (o !== x) begin n_fail++; $display("FAIL gap_word got %h want %h", o, x); end
        end
        obs_q.delete(); exp_q.delete(); vcyc.delete();
    endtask

    task automatic test_back_to_back;
        send_word(8'h3C);
        n_cmp++; if (Q !== 8'h3C) begin n_fail++; $display("FAIL b2b_first got %h want 3c", Q); end
        send_word(8'hC3);
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
        if (vcyc.size() == 2) begin
            n_cmp++; if (vcyc[1] - vcyc[0] != 8) begin n_fail++; $display("FAIL b2b_spacing got %0d want 8", vcyc[1] - vcyc[0]); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_cmp++; if (o !== x) begin n_fail++; $display("FAIL b2b_word got %h want %h", o, x); end
        end
        obs_q.delete(); exp_q.delete(); vcyc.delete();
    endtask

    task automatic test_sync_err;
        logic [7:0] w = 8'h5A;
        int e0 = err_cnt;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(w);
        cyc(1'b1, 1'b1, w[0]);
        n_cmp++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_pulse got %b want 1", sync_err); end
        n_cmp++; if (Q !== 8'hC3) begin n_fail++; $display("FAIL sync_oldq got %h want c3", Q); end
        n_cmp++; if (slot !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL sync_slot got %0d/%b want 1/1", slot, busy); end
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, w[i]);
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL sync_errcnt got %0d want 1", err_cnt - e0); end
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL sync_count got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_cmp++; if (o !== x) begin n_fail++; $display("FAIL sync_word got %h want %h", o, x); end
        end
        obs_q.delete(); exp_q.delete(); vcyc.delete();
    endtask

    task automatic test_stray_reset;
        int e0;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0 || slot !== 3'd0) begin n_fail++; $display("FAIL stray_idle got %b/%0d want 0/0", busy, slot); end
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
        n_cmp++; if (slot !== 3'd4) begin n_fail++; $display("FAIL stray_slot got %0d want 4", slot); end
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b0 || slot !== 3'd0) begin n_fail++; $display("FAIL midrst_state got %b/%0d want 0/0", busy, slot); end
        n_cmp++; if (Q !== 8'h00) begin n_fail++; $display("FAIL midrst_q got %h want 00", Q); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_valid got %0d want 0", obs_q.size()); end
        n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL midrst_err got %0d want 0", err_cnt - e0); end
        obs_q.delete(); exp_q.delete(); vcyc.delete();
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_gapped;
        test_back_to_back;
        test_sync_err;
        test_stray_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
